// File: rtl/sb_spram_pkg.sv
// Shared constants for the iCE40 UltraPlus single-port SRAM model.
package sb_spram_pkg;
    localparam int unsigned SPRAM_DATA_W = 16;
    localparam int unsigned SPRAM_ADDR_W = 14;
    localparam int unsigned SPRAM_DEPTH  = 16384;
    localparam int unsigned SPRAM_MASK_W = 4;
endpackage

// File: rtl/spram_nibble_mask.sv
// Expands a per-nibble write mask into a per-bit write enable vector.
module spram_nibble_mask #(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W/4-1:0] i_mask,
    output logic [DATA_W-1:0]   o_bit_en
);
    for (genvar g = 0; g < DATA_W / 4; g++) begin : g_nibble
        assign o_bit_en[4*g +: 4] = {4{i_mask[g]}};
    end
endmodule

// File: rtl/sb_spram256ka.sv
// 16K x 16 single-port SRAM with nibble write mask and registered read port.
// Optional STANDBY/SLEEP/POWEROFF ports are enabled with SPRAM_POWER_PORTS_EN.
module sb_spram256ka
    import sb_spram_pkg::*;
#(
    parameter int unsigned DATA_W = SPRAM_DATA_W,
    parameter int unsigned ADDR_W = SPRAM_ADDR_W
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [ADDR_W-1:0]   ADDRESS,
    input  logic [DATA_W-1:0]   DATAIN,
    input  logic [DATA_W/4-1:0] MASKWREN,
    input  logic                WREN,
    input  logic                CHIPSELECT,
`ifdef SPRAM_POWER_PORTS_EN
    input  logic                STANDBY,
    input  logic                SLEEP,
    input  logic                POWEROFF,
`endif
    output logic [DATA_W-1:0]   DATAOUT
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    logic              w_standby;
    logic              w_sleep;
    logic              w_powered;
    logic              w_access;
    logic [DATA_W-1:0] w_bit_en;
    logic [DATA_W-1:0] r_mem [Depth];
    logic [DATA_W-1:0] r_dataout;

`ifdef SPRAM_POWER_PORTS_EN
    assign w_standby = STANDBY;
    assign w_sleep   = SLEEP;
    assign w_powered = POWEROFF;
`else
    assign w_standby = 1'b0;
    assign w_sleep   = 1'b0;
    assign w_powered = 1'b1;
`endif

    assign w_access = CHIPSELECT & ~w_standby & ~w_sleep & w_powered;

    spram_nibble_mask #(
        .DATA_W (DATA_W)
    ) u_mask (
        .i_mask   (MASKWREN),
        .o_bit_en (w_bit_en)
    );

    // Storage is never cleared; reset only suppresses a concurrent write.
    always_ff @(posedge CLOCK) begin
        if (!RESET && w_access && WREN) begin
            r_mem[ADDRESS] <= (r_mem[ADDRESS] & ~w_bit_en) | (DATAIN & w_bit_en);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_dataout <= '0;
        end else if (!w_powered || w_sleep) begin
            r_dataout <= '0;
        end else if (w_access && !WREN) begin
            r_dataout <= r_mem[ADDRESS];
        end
    end

    assign DATAOUT = r_dataout;
endmodule

// File: tb/tb_sb_spram256ka.sv
// Self-checking bench for sb_spram256ka: directed cases plus a randomized run
// against a nibble-level behavioural model.
module tb_sb_spram256ka;
    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] addr;
    logic [15:0] din;
    logic [3:0]  mask;
    logic        wren;
    logic        cs;
    logic [15:0] dout;
`ifdef SPRAM_POWER_PORTS_EN
    logic        standby;
    logic        sleep;
    logic        poweroff;
`endif

    int errors = 0;
    int checks = 0;

    logic [15:0] model_mem [int];
    logic [15:0] model_out;
    logic [13:0] pool [8];

    always #5 clk = ~clk;

    sb_spram256ka dut (
        .CLOCK      (clk),
        .RESET      (rst),
        .ADDRESS    (addr),
        .DATAIN     (din),
        .MASKWREN   (mask),
        .WREN       (wren),
        .CHIPSELECT (cs),
`ifdef SPRAM_POWER_PORTS_EN
        .STANDBY    (standby),
        .SLEEP      (sleep),
        .POWEROFF   (poweroff),
`endif
        .DATAOUT    (dout)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs already set up, clock once, then settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model of one clock edge, written from the access rules directly.
    task automatic model_edge();
        logic [15:0] word;
        if (rst) begin
            model_out = 16'h0;
        end else if (cs && wren) begin
            word = model_mem.exists(int'(addr)) ? model_mem[int'(addr)] : 16'h0;
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) word[4*i +: 4] = din[4*i +: 4];
            end
            model_mem[int'(addr)] = word;
        end else if (cs) begin
            model_out = model_mem[int'(addr)];
        end
    endtask

    task automatic cycle(input logic r, input logic c, input logic w, input logic [13:0] a,
                         input logic [15:0] d, input logic [3:0] m);
        rst = r; cs = c; wren = w; addr = a; din = d; mask = m;
        model_edge();
        step();
        rst = 1'b0; cs = 1'b0; wren = 1'b0;
    endtask

    task automatic do_write(input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
        cycle(1'b0, 1'b1, 1'b1, a, d, m);
    endtask

    task automatic do_read(input logic [13:0] a);
        cycle(1'b0, 1'b1, 1'b0, a, 16'h0, 4'h0);
    endtask

    initial begin
        rst = 1'b0; cs = 1'b0; wren = 1'b0; addr = '0; din = '0; mask = '0;
`ifdef SPRAM_POWER_PORTS_EN
        standby = 1'b0; sleep = 1'b0; poweroff = 1'b1;
`endif
        model_out = 16'h0;
        repeat (2) @(posedge clk);
        #1;

        cycle(1'b1, 1'b0, 1'b0, 14'h0, 16'h0, 4'h0);
        check("reset_out", dout, 16'h0000);

        do_write(14'h0123, 16'hBEEF, 4'hF);
        do_read(14'h0123);
        check("full_write_read", dout, 16'hBEEF);

        do_write(14'h0010, 16'h1234, 4'hF);
        do_write(14'h0010, 16'hABCD, 4'h5);
        do_read(14'h0010);
        check("nibble_mask", dout, 16'h1B3D);

        do_write(14'h0020, 16'h1111, 4'hF);
        do_read(14'h0020);
        check("read_1111", dout, 16'h1111);
        do_write(14'h0030, 16'h2222, 4'hF);
        check("write_holds_out", dout, 16'h1111);
        cycle(1'b0, 1'b0, 1'b1, 14'h0020, 16'h3333, 4'hF);
        check("cs0_holds_out", dout, 16'h1111);
        do_read(14'h0030);
        check("read_2222", dout, 16'h2222);
        do_read(14'h0020);
        check("cs0_no_write", dout, 16'h1111);
        do_write(14'h0020, 16'hFFFF, 4'h0);
        do_read(14'h0020);
        check("mask0_no_write", dout, 16'h1111);

        do_read(14'h0123);
        check("pre_reset_read", dout, 16'hBEEF);
        cycle(1'b1, 1'b1, 1'b1, 14'h0123, 16'h0000, 4'hF);
        check("reset_clears_out", dout, 16'h0000);
        do_read(14'h0123);
        check("reset_blocks_write", dout, 16'hBEEF);

        do_write(14'h3FFF, 16'hA5A5, 4'hF);
        do_write(14'h0000, 16'h5A5A, 4'hF);
        do_read(14'h3FFF);
        check("addr_top", dout, 16'hA5A5);
        do_read(14'h0000);
        check("addr_bottom", dout, 16'h5A5A);

`ifdef SPRAM_POWER_PORTS_EN
        do_read(14'h0123);
        sleep = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 14'h0123, 16'h0, 4'h0);
        check("sleep_forces_zero", dout, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 14'h0123, 16'h7777, 4'hF);
        check("sleep_write_out", dout, 16'h0000);
        sleep = 1'b0;
        do_read(14'h0123);
        check("post_sleep_read", dout, 16'hBEEF);
        standby = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 14'h0000, 16'h0, 4'h0);
        check("standby_holds", dout, 16'hBEEF);
        standby = 1'b0;
`endif

        // Randomized traffic over a small pool of initialised addresses.
        for (int i = 0; i < 8; i++) begin
            pool[i] = 14'($urandom_range(0, 16383));
            do_write(pool[i], 16'($urandom), 4'hF);
        end
        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), pool[$urandom_range(0, 7)], 16'($urandom), 4'($urandom));
            check("random_out", dout, model_out);
        end
        for (int i = 0; i < 8; i++) begin
            do_read(pool[i]);
            check("random_final", dout, model_out);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
